forward_ctrl: RTL and testbench
===============================

# forward_ctrl

Forwarding and load-use hazard controller for the 5-stage pipeline. It generates the 2-bit operand-select codes consumed by the ALU-operand forwarding multiplexers: 00 register file, 01 MEM/WB, 10 EX/MEM. It keeps its own shadow copy of destination-register, RegWrite and MemRead state for the EX, MEM and WB stages. It issues the ID-stage stall for load-use dependencies and counts stall cycles for performance debug.

## Interface
Parameters:
- REG_AW, 5, register-address width
- CNT_W, 16, stall-counter width

Ports:
- clk_i  in  1  clock. Single clock domain.
- rst_i  in  1  reset. Synchronous, active-high.
- id_valid_i  in  1  ID stage holds a real instruction
- id_rs_i  in  REG_AW  source register A of the ID instruction
- id_rt_i  in  REG_AW  source register B of the ID instruction
- id_rd_i  in  REG_AW  destination register of the ID instruction, already muxed rt/rd
- id_regwrite_i  in  1  ID instruction writes the register file
- id_memread_i  in  1  ID instruction is a load
- flush_i  in  1  squash the ID instruction (taken branch/jump)
- fwd_a_o  out  2  select code for ALU operand A of the instruction in EX
- fwd_b_o  out  2  select code for ALU operand B of the instruction in EX
- stall_o  out  1  hold PC and IF/ID; insert bubble into EX
- stall_cnt_o  out  CNT_W  saturating count of stall cycles

## Operation
- Shadow stages:
  - EX: ex_rd, ex_rw, ex_mr
  - MEM: mem_rd, mem_rw, mem_mr
  - WB: wb_rd, wb_rw
  - All shadow stages advance every cycle; there is no external pipeline enable.
- EX-stage load from ID:
  - Loads ID fields when id_valid_i && !flush_i && !stall_o.
  - Otherwise loads a bubble: rw=0, mr=0, rd=0.
- Load-use hazard:
  - hazard = ex_mr && ex_rw && ex_rd!=0 && (ex_rd==id_rs_i || ex_rd==id_rt_i).
  - stall_o = hazard && id_valid_i && !flush_i. This output is combinational from state and inputs.
- Select code for each operand, with operand register s = id_rs_i (A) or id_rt_i (B):
  - 10 if ex_rw && ex_rd!=0 && ex_rd==s. Current EX becomes EX/MEM next cycle.
  - Otherwise 01 if mem_rw && mem_rd!=0 && mem_rd==s. Current MEM becomes MEM/WB next cycle.
  - Otherwise 00.
  - EX/MEM has priority over MEM/WB.
- Forwarding outputs:
  - fwd_a_o/fwd_b_o are registered and update on the edge at which the instruction enters EX.
  - When a bubble is loaded, both outputs load 00.
- Register 0 is never forwarded and never causes a stall.
- Stall counter:
  - stall_cnt_o increments by 1 on each clock edge where stall_o=1.
  - It saturates at 2^CNT_W-1 and holds there.
  - It clears only on reset.

## Timing
- Reset, synchronous: on the reset edge, all shadow rd fields go to 0, all rw/mr bits to 0, fwd_a_o=fwd_b_o=00 and stall_cnt_o=0. stall_o therefore reads 0 in the cycle after the reset edge.
- Select latency: a select code is valid in the same cycle the instruction occupies EX, i.e. one edge after it was presented on the ID inputs.
- Load-use stall length:
  - A load-use stall lasts exactly one cycle.
  - After the bubble, the load sits in MEM and the dependent instruction re-presents in ID.
  - When that instruction enters EX, the load has reached MEM/WB, so the select is 01.
- flush_i and hazard in the same cycle: flush_i wins. stall_o=0 and a bubble enters EX.
- Reset asserted mid-stall: reset wins. All state clears and the counter does not increment on that edge.
- WB shadow stage: it is tracking only (its contents are not used by any output). Write-before-read through the register file is assumed handled by the register file, so WB never drives a select code.

## Structure
- Package forward_pkg holds the select constants:
  - FWD_REG=2'b00
  - FWD_MEMWB=2'b01
  - FWD_EXMEM=2'b10
- Sub-module fwd_sel: combinational priority comparator, instantiated twice (operands A and B).
  - Inputs: src, ex_rd, ex_rw, mem_rd, mem_rw.
  - Output: 2-bit select code.

## Test plan
- Back-to-back dependency: add $3 ← $1,$2, then sub $4 ← $3,$5 on the next cycle → the sub in EX gets fwd_a_o=10, fwd_b_o=00, stall_o never asserted.
- Distance two: add $3, nop, or $6 ← $7,$3 → the or in EX gets fwd_b_o=01.
- Both stages match $3: add $3, add $3, sub ← $3,$3 → fwd_a_o=fwd_b_o=10 (EX/MEM priority).
- Load-use: lw $8, then add ← $8,$9 → stall_o=1 for exactly one cycle. Then the add enters EX with fwd_a_o=01, and stall_cnt_o goes 0→1.
- $0 and flush:
  - Instruction writing $0 followed by a reader of $0 → select 00, no stall.
  - lw $8 followed by a dependent instruction with flush_i=1 → stall_o=0, a bubble enters EX, and the next fwd outputs are 00.
- Reset and saturation:
  - With CNT_W=2, force 5 stalls → stall_cnt_o holds at 3.
  - Asserting rst_i mid-stall → all outputs return to 0 on the next edge.

Source files
------------

// File: rtl/forward_ctrl_pkg.sv
// forward_pkg: shared constants for the forwarding/hazard controller.
//   FWD_REG   - operand comes from the register file
//   FWD_MEMWB - operand comes from the MEM/WB pipeline register
//   FWD_EXMEM - operand comes from the EX/MEM pipeline register
package forward_pkg;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

endpackage

// File: rtl/forward_ctrl_if.sv
// forward_ctrl_if: ID-stage request / forwarding-control response bundle.
//   master - drives the ID-stage instruction fields and flush, reads selects/stall/count
//   slave  - the forwarding controller side
interface forward_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);

  logic              id_valid_i;
  logic [REG_AW-1:0] id_rs_i;
  logic [REG_AW-1:0] id_rt_i;
  logic [REG_AW-1:0] id_rd_i;
  logic              id_regwrite_i;
  logic              id_memread_i;
  logic              flush_i;
  logic [1:0]        fwd_a_o;
  logic [1:0]        fwd_b_o;
  logic              stall_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  modport master (
    output id_valid_i, id_rs_i, id_rt_i, id_rd_i, id_regwrite_i, id_memread_i, flush_i,
    input  fwd_a_o, fwd_b_o, stall_o, stall_cnt_o
  );

  modport slave (
    input  id_valid_i, id_rs_i, id_rt_i, id_rd_i, id_regwrite_i, id_memread_i, flush_i,
    output fwd_a_o, fwd_b_o, stall_o, stall_cnt_o
  );

endinterface

// File: rtl/forward_ctrl_fwd_sel.sv
// fwd_sel: combinational priority comparator producing one operand select code.
//   src    - source register of the instruction entering EX
//   ex_rd  / ex_rw  - destination/write-enable of the instruction now in EX
//   mem_rd / mem_rw - destination/write-enable of the instruction now in MEM
//   sel    - FWD_EXMEM, FWD_MEMWB or FWD_REG
module fwd_sel
  import forward_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_rw,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_rw,
  output logic [1:0]        sel
);

  logic ex_hit_s;
  logic mem_hit_s;

  // Match detection against both forwarding sources; register 0 never matches.
  always_comb begin
    ex_hit_s  = ex_rw  && (ex_rd  != {REG_AW{1'b0}}) && (ex_rd  == src);
    mem_hit_s = mem_rw && (mem_rd != {REG_AW{1'b0}}) && (mem_rd == src);
  end

  // Priority pick: the EX instruction is younger, so its value wins.
  always_comb begin
    if (ex_hit_s) begin
      sel = FWD_EXMEM;
    end else if (mem_hit_s) begin
      sel = FWD_MEMWB;
    end else begin
      sel = FWD_REG;
    end
  end

endmodule

// File: rtl/forward_ctrl.sv
// forward_ctrl: forwarding-select and load-use stall controller for a 5-stage pipeline.
//   clk_i - clock
//   rst_i - synchronous active-high reset
//   bus   - forward_ctrl_if.slave: ID-stage fields and flush in; fwd_a_o/fwd_b_o
//           (registered), stall_o (combinational), stall_cnt_o (saturating) out
module forward_ctrl
  import forward_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  forward_ctrl_if.slave bus
);

  localparam logic [REG_AW-1:0] RD_ZERO = {REG_AW{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [REG_AW-1:0] ex_rd_q,  ex_rd_d;
  logic              ex_rw_q,  ex_rw_d;
  logic              ex_mr_q,  ex_mr_d;
  logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
  logic              mem_rw_q, mem_rw_d;
  logic              mem_mr_q, mem_mr_d;
  logic [REG_AW-1:0] wb_rd_q,  wb_rd_d;
  logic              wb_rw_q,  wb_rw_d;
  logic [1:0]        fwd_a_q,  fwd_a_d;
  logic [1:0]        fwd_b_q,  fwd_b_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;

  logic       hazard_s;
  logic       stall_s;
  logic       load_s;
  logic [1:0] sel_a_s;
  logic [1:0] sel_b_s;

  // The WB shadow and MEM load flag are kept for debug visibility only.
  logic unused_shadow_s;
  assign unused_shadow_s = ^{wb_rd_q, wb_rw_q, mem_mr_q};

  fwd_sel #(.REG_AW(REG_AW)) u_sel_a (
    .src    (bus.id_rs_i),
    .ex_rd  (ex_rd_q),
    .ex_rw  (ex_rw_q),
    .mem_rd (mem_rd_q),
    .mem_rw (mem_rw_q),
    .sel    (sel_a_s)
  );

  fwd_sel #(.REG_AW(REG_AW)) u_sel_b (
    .src    (bus.id_rt_i),
    .ex_rd  (ex_rd_q),
    .ex_rw  (ex_rw_q),
    .mem_rd (mem_rd_q),
    .mem_rw (mem_rw_q),
    .sel    (sel_b_s)
  );

  // Load-use detection: a load in EX cannot forward in time to the ID instruction.
  always_comb begin
    hazard_s = ex_mr_q && ex_rw_q && (ex_rd_q != RD_ZERO) &&
               ((ex_rd_q == bus.id_rs_i) || (ex_rd_q == bus.id_rt_i));
    stall_s  = hazard_s && bus.id_valid_i && !bus.flush_i;
    load_s   = bus.id_valid_i && !bus.flush_i && !stall_s;
  end

  // Next-state: shadow pipeline advance, select capture, stall counting.
  always_comb begin
    if (load_s) begin
      ex_rd_d = bus.id_rd_i;
      ex_rw_d = bus.id_regwrite_i;
      ex_mr_d = bus.id_memread_i;
      fwd_a_d = sel_a_s;
      fwd_b_d = sel_b_s;
    end else begin
      ex_rd_d = RD_ZERO;
      ex_rw_d = 1'b0;
      ex_mr_d = 1'b0;
      fwd_a_d = FWD_REG;
      fwd_b_d = FWD_REG;
    end
    mem_rd_d = ex_rd_q;
    mem_rw_d = ex_rw_q;
    mem_mr_d = ex_mr_q;
    wb_rd_d  = mem_rd_q;
    wb_rw_d  = mem_rw_q;
    if (stall_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_rd_q  <= RD_ZERO;
      ex_rw_q  <= 1'b0;
      ex_mr_q  <= 1'b0;
      mem_rd_q <= RD_ZERO;
      mem_rw_q <= 1'b0;
      mem_mr_q <= 1'b0;
      wb_rd_q  <= RD_ZERO;
      wb_rw_q  <= 1'b0;
      fwd_a_q  <= FWD_REG;
      fwd_b_q  <= FWD_REG;
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      ex_rd_q  <= ex_rd_d;
      ex_rw_q  <= ex_rw_d;
      ex_mr_q  <= ex_mr_d;
      mem_rd_q <= mem_rd_d;
      mem_rw_q <= mem_rw_d;
      mem_mr_q <= mem_mr_d;
      wb_rd_q  <= wb_rd_d;
      wb_rw_q  <= wb_rw_d;
      fwd_a_q  <= fwd_a_d;
      fwd_b_q  <= fwd_b_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.fwd_a_o     = fwd_a_q;
  assign bus.fwd_b_o     = fwd_b_q;
  assign bus.stall_o     = stall_s;
  assign bus.stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_forward_ctrl.sv
// tb_forward_ctrl: directed pipeline scenarios plus randomized traffic, checked
// every cycle against an instruction-history model of the forwarding rules.
module tb_forward_ctrl;

  localparam int AW = 5;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  forward_ctrl_if #(.REG_AW(AW), .CNT_W(CW)) bus ();

  forward_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---- Behavioural model: history of what entered EX, newest first ----
  typedef struct {
    int rd;
    bit rw;
    bit mr;
  } ent_t;

  ent_t hist[3];
  bit   model_ok = 1'b0;
  int   m_fa = 0;
  int   m_fb = 0;
  int   m_cnt = 0;
  int   cnt_max = (1 << CW) - 1;

  // select code for source register s, given instructions one and two slots ahead
  function automatic int model_sel(input int s);
    if (s != 0 && hist[0].rw && hist[0].rd == s) return 2;
    if (s != 0 && hist[1].rw && hist[1].rd == s) return 1;
    return 0;
  endfunction

  function automatic bit model_stall();
    bit uses;
    uses = (hist[0].rd == int'(bus.id_rs_i)) || (hist[0].rd == int'(bus.id_rt_i));
    return hist[0].mr && hist[0].rw && hist[0].rd != 0 && uses &&
           bus.id_valid_i && !bus.flush_i;
  endfunction

  always @(posedge clk) begin
    bit st;
    bit ld;
    ent_t nw;
    if (rst) begin
      for (int i = 0; i < 3; i++) hist[i] = '{0, 1'b0, 1'b0};
      m_fa = 0; m_fb = 0; m_cnt = 0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      st = model_stall();
      ld = bus.id_valid_i && !bus.flush_i && !st;
      if (ld) begin
        m_fa = model_sel(int'(bus.id_rs_i));
        m_fb = model_sel(int'(bus.id_rt_i));
        nw = '{int'(bus.id_rd_i), bus.id_regwrite_i, bus.id_memread_i};
      end else begin
        m_fa = 0; m_fb = 0;
        nw = '{0, 1'b0, 1'b0};
      end
      if (st && m_cnt < cnt_max) m_cnt++;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = nw;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("stall_o",     int'(bus.stall_o),     int'(model_stall()));
      chk("fwd_a_o",     int'(bus.fwd_a_o),     m_fa);
      chk("fwd_b_o",     int'(bus.fwd_b_o),     m_fb);
      chk("stall_cnt_o", int'(bus.stall_cnt_o), m_cnt);
    end
  end

  // ---- Stimulus helpers ----
  logic last_stall;

  task automatic drive(input bit v, input int rs, input int rt, input int rd,
                       input bit rw, input bit mr, input bit fl);
    bus.id_valid_i    = v;
    bus.id_rs_i       = AW'(rs);
    bus.id_rt_i       = AW'(rt);
    bus.id_rd_i       = AW'(rd);
    bus.id_regwrite_i = rw;
    bus.id_memread_i  = mr;
    bus.flush_i       = fl;
  endtask

  // present one ID instruction for one cycle; last_stall holds stall_o seen meanwhile
  task automatic issue(input bit v, input int rs, input int rt, input int rd,
                       input bit rw, input bit mr, input bit fl);
    drive(v, rs, rt, rd, rw, mr, fl);
    #1;
    last_stall = bus.stall_o;
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    issue(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    // reset state
    chk("rst_fwd_a", int'(bus.fwd_a_o), 0);
    chk("rst_fwd_b", int'(bus.fwd_b_o), 0);
    chk("rst_stall", int'(bus.stall_o), 0);
    chk("rst_cnt",   int'(bus.stall_cnt_o), 0);
    rst = 1'b0;

    // back-to-back: add $3<-$1,$2 ; sub $4<-$3,$5
    issue(1'b1, 1, 2, 3, 1'b1, 1'b0, 1'b0);
    issue(1'b1, 3, 5, 4, 1'b1, 1'b0, 1'b0);
    chk("b2b_stall", int'(last_stall), 0);
    chk("b2b_fwd_a", int'(bus.fwd_a_o), 2);
    chk("b2b_fwd_b", int'(bus.fwd_b_o), 0);
    nop(); nop();

    // distance two: add $3 ; nop ; or $6<-$7,$3
    issue(1'b1, 1, 2, 3, 1'b1, 1'b0, 1'b0);
    nop();
    issue(1'b1, 7, 3, 6, 1'b1, 1'b0, 1'b0);
    chk("d2_fwd_a", int'(bus.fwd_a_o), 0);
    chk("d2_fwd_b", int'(bus.fwd_b_o), 1);
    nop(); nop();

    // both stages write $3: EX/MEM wins
    issue(1'b1, 1, 2, 3, 1'b1, 1'b0, 1'b0);
    issue(1'b1, 1, 2, 3, 1'b1, 1'b0, 1'b0);
    issue(1'b1, 3, 3, 4, 1'b1, 1'b0, 1'b0);
    chk("prio_fwd_a", int'(bus.fwd_a_o), 2);
    chk("prio_fwd_b", int'(bus.fwd_b_o), 2);
    nop(); nop();

    // load-use: lw $8 ; add <-$8,$9 (stalls once, then forwards from MEM/WB)
    chk("lu_cnt0", int'(bus.stall_cnt_o), 0);
    issue(1'b1, 1, 0, 8, 1'b1, 1'b1, 1'b0);
    issue(1'b1, 8, 9, 10, 1'b1, 1'b0, 1'b0);
    chk("lu_stall1", int'(last_stall), 1);
    chk("lu_bubble_a", int'(bus.fwd_a_o), 0);
    issue(1'b1, 8, 9, 10, 1'b1, 1'b0, 1'b0);
    chk("lu_stall2", int'(last_stall), 0);
    chk("lu_fwd_a", int'(bus.fwd_a_o), 1);
    chk("lu_fwd_b", int'(bus.fwd_b_o), 0);
    chk("lu_cnt1", int'(bus.stall_cnt_o), 1);
    nop(); nop();

    // $0: writer of $0 then reader of $0; load to $0 then reader of $0
    issue(1'b1, 1, 2, 0, 1'b1, 1'b0, 1'b0);
    issue(1'b1, 0, 0, 5, 1'b1, 1'b0, 1'b0);
    chk("r0_fwd_a", int'(bus.fwd_a_o), 0);
    chk("r0_fwd_b", int'(bus.fwd_b_o), 0);
    issue(1'b1, 1, 0, 0, 1'b1, 1'b1, 1'b0);
    issue(1'b1, 0, 0, 5, 1'b1, 1'b0, 1'b0);
    chk("r0_stall", int'(last_stall), 0);
    nop(); nop();

    // flush beats hazard
    issue(1'b1, 1, 0, 8, 1'b1, 1'b1, 1'b0);
    issue(1'b1, 8, 8, 11, 1'b1, 1'b0, 1'b1);
    chk("fl_stall", int'(last_stall), 0);
    chk("fl_fwd_a", int'(bus.fwd_a_o), 0);
    chk("fl_fwd_b", int'(bus.fwd_b_o), 0);
    nop(); nop();

    // saturation: 5 more stalls on a 2-bit counter that already holds 1
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, 1, 0, 8, 1'b1, 1'b1, 1'b0);
      issue(1'b1, 9, 8, 12, 1'b1, 1'b0, 1'b0);
      chk("sat_stall", int'(last_stall), 1);
      issue(1'b1, 9, 8, 12, 1'b1, 1'b0, 1'b0);
    end
    chk("sat_cnt", int'(bus.stall_cnt_o), 3);

    // reset asserted while a stall is active
    issue(1'b1, 1, 0, 8, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 8, 9, 10, 1'b1, 1'b0, 1'b0);
    #1;
    chk("mid_stall_pre", int'(bus.stall_o), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_stall", int'(bus.stall_o), 0);
    chk("mid_rst_fwd_a", int'(bus.fwd_a_o), 0);
    chk("mid_rst_fwd_b", int'(bus.fwd_b_o), 0);
    chk("mid_rst_cnt",   int'(bus.stall_cnt_o), 0);
    nop();

    // randomized traffic over a small register window to provoke matches
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        issue(($urandom_range(0, 9) != 0),
              int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 4)),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 9) == 0));
      end
    end

    nop();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
